btn_conditioner: RTL



---
 rtl/btn_conditioner.sv | 139 +++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton conditioner: per-bit two-flop synchronizer, stable-time
// debounce, press/release edge pulses and an auto-repeat pulse train for held buttons.
module btn_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic [WIDTH-1:0] btn_repeat
);

  localparam int CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HCNT_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] DELAY_V   = HCNT_W'(REPEAT_DELAY);
  localparam logic [HCNT_W-1:0] PERIOD_V  = HCNT_W'(REPEAT_PERIOD);
  localparam bit                REPEAT_EN = (REPEAT_DELAY != 0);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [WIDTH-1:0] level_r;
  logic [WIDTH-1:0] level_d_r;
  logic [WIDTH-1:0] rep_r;
  logic [WIDTH-1:0] level_nxt_s;
  logic [WIDTH-1:0] rep_nxt_s;

  // Two-flop synchronizer for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= {WIDTH{1'b0}};
      s2_r <= {WIDTH{1'b0}};
    end else begin
      s1_r <= btn_raw;
      s2_r <= s1_r;
    end
  end

  // Debounced level, its delayed copy and the look-ahead repeat pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r   <= {WIDTH{1'b0}};
      level_d_r <= {WIDTH{1'b0}};
      rep_r     <= {WIDTH{1'b0}};
    end else begin
      level_r   <= level_nxt_s;
      level_d_r <= level_r;
      rep_r     <= rep_nxt_s;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              lvl_nxt_s;
    logic [HCNT_W-1:0] hcnt_r;
    logic [HCNT_W-1:0] hcnt_nxt_s;
    logic              first_r;
    logic              first_nxt_s;
    logic              pulse_nxt_s;

    // Stable-time debounce: any return of s2 to the current level restarts the count
    always_comb begin
      cnt_nxt_s = cnt_r;
      lvl_nxt_s = level_r[i];
      if (s2_r[i] == level_r[i]) begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        lvl_nxt_s = s2_r[i];
        cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end

    // Hold counter and phase flag; repeat is registered one cycle ahead so the
    // output comes straight from a flop and lands in the cycle hcnt hits its target
    always_comb begin
      hcnt_nxt_s  = hcnt_r;
      first_nxt_s = first_r;
      pulse_nxt_s = 1'b0;
      if (level_r[i] && !level_d_r[i]) begin
        hcnt_nxt_s  = HCNT_W'(1);
        first_nxt_s = 1'b1;
      end else if (level_r[i]) begin
        if (!REPEAT_EN) begin
          hcnt_nxt_s = hcnt_r;
        end else if (first_r && (hcnt_r == DELAY_V)) begin
          hcnt_nxt_s  = HCNT_W'(1);
          first_nxt_s = 1'b0;
        end else if (!first_r && (hcnt_r == PERIOD_V)) begin
          hcnt_nxt_s = HCNT_W'(1);
        end else begin
          hcnt_nxt_s = hcnt_r + HCNT_W'(1);
        end
      end else begin
        hcnt_nxt_s  = {HCNT_W{1'b0}};
        first_nxt_s = 1'b1;
      end

      if (lvl_nxt_s && !level_r[i]) begin
        pulse_nxt_s = 1'b1;
      end else if (lvl_nxt_s && REPEAT_EN) begin
        pulse_nxt_s = first_nxt_s ? (hcnt_nxt_s == DELAY_V) : (hcnt_nxt_s == PERIOD_V);
      end else begin
        pulse_nxt_s = 1'b0;
      end
    end

    // Per-channel counter state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r   <= {CNT_W{1'b0}};
        hcnt_r  <= {HCNT_W{1'b0}};
        first_r <= 1'b1;
      end else begin
        cnt_r   <= cnt_nxt_s;
        hcnt_r  <= hcnt_nxt_s;
        first_r <= first_nxt_s;
      end
    end

    assign level_nxt_s[i] = lvl_nxt_s;
    assign rep_nxt_s[i]   = pulse_nxt_s;
  end

  assign btn_level   = level_r;
  assign btn_press   = level_r & ~level_d_r;
  assign btn_release = ~level_r & level_d_r;
  assign btn_repeat  = rep_r;

endmodule
